// File: rtl/serial_eq_checker_amisha_if.sv
// rtl/serial_eq_checker_amisha_if.sv - bit-pair stream and frame result bundle for the serial equality checker
interface serial_eq_checker_amisha_if #(
  parameter int IDX_W = 3
);
  logic             start_amisha;
  logic             abort_amisha;
  logic             bit_valid_amisha;
  logic             i0_amisha;
  logic             i1_amisha;
  logic             busy_amisha;
  logic             done_amisha;
  logic             eq_word_amisha;
  logic [IDX_W:0]   mism_cnt_amisha;
  logic [IDX_W-1:0] first_mism_idx_amisha;

  modport master (
    output start_amisha, abort_amisha, bit_valid_amisha, i0_amisha, i1_amisha,
    input  busy_amisha, done_amisha, eq_word_amisha, mism_cnt_amisha, first_mism_idx_amisha
  );

  modport slave (
    input  start_amisha, abort_amisha, bit_valid_amisha, i0_amisha, i1_amisha,
    output busy_amisha, done_amisha, eq_word_amisha, mism_cnt_amisha, first_mism_idx_amisha
  );
endinterface

// File: rtl/serial_eq_checker_amisha.sv
// rtl/serial_eq_checker_amisha.sv - frame-level equality checker over a serial stream of bit pairs
module serial_eq_checker_amisha #(
  parameter int N_BITS = 8,
  parameter int IDX_W  = 3
) (
  input  logic                       clk_amisha,
  input  logic                       rst_n_amisha,
  serial_eq_checker_amisha_if.slave  bus
);
  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_CMP   = 2'd1;
  localparam logic [1:0]       ST_DONE  = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W:0]   run_cnt;
  logic             first_seen;
  logic [IDX_W-1:0] run_first_idx;

  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic [IDX_W:0]   cnt_q;
  logic [IDX_W-1:0] idx_q;

  logic             mism;
  logic [IDX_W:0]   cnt_next;
  logic [IDX_W-1:0] first_next;

  // Running totals including the pair presented this cycle, so the last
  // pair can be folded into the result on the same edge.
  always_comb begin
    mism       = bus.i0_amisha ^ bus.i1_amisha;
    cnt_next   = run_cnt + {{IDX_W{1'b0}}, mism};
    first_next = (mism && !first_seen) ? bit_idx : run_first_idx;
  end

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state         <= ST_IDLE;
      bit_idx       <= '0;
      run_cnt       <= '0;
      first_seen    <= 1'b0;
      run_first_idx <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      eq_q          <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_amisha) begin
            state         <= ST_CMP;
            busy_q        <= 1'b1;
            bit_idx       <= '0;
            run_cnt       <= '0;
            first_seen    <= 1'b0;
            run_first_idx <= '0;
          end
        end
        ST_CMP: begin
          // Abort wins even over a simultaneous last pair.
          if (bus.abort_amisha) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (bus.bit_valid_amisha) begin
            run_cnt       <= cnt_next;
            run_first_idx <= first_next;
            first_seen    <= first_seen | mism;
            if (bit_idx == LAST_IDX) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              eq_q   <= (cnt_next == '0);
              cnt_q  <= cnt_next;
              idx_q  <= first_next;
            end else begin
              bit_idx <= bit_idx + IDX_ONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.start_amisha) begin
            state         <= ST_CMP;
            busy_q        <= 1'b1;
            bit_idx       <= '0;
            run_cnt       <= '0;
            first_seen    <= 1'b0;
            run_first_idx <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_amisha           = busy_q;
  assign bus.done_amisha           = done_q;
  assign bus.eq_word_amisha        = eq_q;
  assign bus.mism_cnt_amisha       = cnt_q;
  assign bus.first_mism_idx_amisha = idx_q;
endmodule
